// File: rtl/ip_rom_reader.sv
// ip_rom_reader: fetches a block of consecutive bytes from an n_cs/n_rd
// read responder, one outstanding read at a time, and presents each byte
// on a valid/ready stream. Used for boot-image copy and ROM self-check.
module ip_rom_reader #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_address,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              n_cs,
   output logic              n_rd,
   output logic [ADDR_W-1:0] address,
   input  logic [7:0]        rdata,
   input  logic              rdata_en,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_FIN
   } state_t;

   // Last WAIT cycle index; the responder gets exactly TIMEOUT cycles.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t              state, state_d;
   logic [ADDR_W-1:0]   addr, addr_d;
   logic [ADDR_W:0]     remaining, remaining_d;
   logic [7:0]          wait_cnt, wait_cnt_d;
   logic                busy_d, done_d, error_d, n_cs_d, n_rd_d, out_valid_d;
   logic [ADDR_W-1:0]   address_d;
   logic [7:0]          out_data_d;
   logic [ADDR_W-1:0]   addr_inc;

   assign addr_inc = addr + ADDR_W'(1);

   // State and every output are registered together; next values come from the comb block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         n_cs      <= 1'b1;
         n_rd      <= 1'b1;
         address   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_d;
         addr      <= addr_d;
         remaining <= remaining_d;
         wait_cnt  <= wait_cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         error     <= error_d;
         n_cs      <= n_cs_d;
         n_rd      <= n_rd_d;
         address   <= address_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
      end
   end

   // Next-state and next-output logic; strobes are computed for the state being
   // entered so that the registered outputs line up with that state.
   always_comb begin
      state_d     = state;
      addr_d      = addr;
      remaining_d = remaining;
      wait_cnt_d  = wait_cnt;
      busy_d      = busy;
      done_d      = 1'b0;
      error_d     = error;
      n_cs_d      = 1'b1;
      n_rd_d      = 1'b1;
      address_d   = address;
      out_data_d  = out_data;
      out_valid_d = out_valid;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               addr_d      = start_address;
               remaining_d = length;
               error_d     = 1'b0;
               busy_d      = 1'b1;
               if (length != '0) begin
                  state_d   = S_REQ;
                  n_cs_d    = 1'b0;
                  n_rd_d    = 1'b0;
                  address_d = start_address;
               end else begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end
            end
         end
         S_REQ: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            if (rdata_en) begin
               out_data_d  = rdata;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else if (wait_cnt == WAIT_LAST) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               wait_cnt_d = wait_cnt + 8'd1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               addr_d      = addr_inc;
               remaining_d = remaining - (ADDR_W + 1)'(1);
               if (remaining == (ADDR_W + 1)'(1)) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d   = S_REQ;
                  n_cs_d    = 1'b0;
                  n_rd_d    = 1'b0;
                  address_d = addr_inc;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
